ahb_arbiter_2m: RTL

AHB_ARBITER_2M -- requirements
Module: ahb_arbiter_2m

---
 rtl/p_hardisc.sv | 44 ++++
 rtl/ahb_hold_stage.sv | 102 ++++++++++
 rtl/ahb_arbiter_2m.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/p_hardisc.sv
`default_nettype none
// ============================================================================
//  Module      : p_hardisc (package)
//  Description : Shared AHB transfer-type constants, per-master state and
//                data-phase owner encodings for the two-master AHB arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package p_hardisc;

    // AHB HTRANS encodings
    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    // Per-master arbitration state
    typedef enum logic [1:0] {
        MST_IDLE   = 2'd0,
        MST_HELD   = 2'd1,
        MST_DPHASE = 2'd2
    } mst_state_e;

    // Which master owns the slave data phase
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_I    = 2'd2
    } owner_e;

    // Captured address-phase content of one master
    typedef struct packed {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [5:0]  hparity;
    } ahb_req_t;

    // A transfer needs the slave only for NONSEQ or SEQ
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == c_HTRANS_NONSEQ) || (htrans == c_HTRANS_SEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_hold_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_hold_stage
//  Description : Per-master front end of the AHB arbiter. Tracks whether the
//                master is idle, stalled with a captured request, or in its
//                data phase, and presents either the live or the held
//                address phase to the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_hold_stage
    import p_hardisc::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    // Master address phase
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic [5:0]  hparity_i,
    // Shared slave ready and arbiter decision
    input  logic        slv_hready_i,
    input  logic        grant_i,
    // Status towards the master and the arbiter
    output logic        hready_o,
    output logic        live_o,
    output logic        held_o,
    // Address phase to forward if this master is granted
    output logic [31:0] req_haddr_o,
    output logic [1:0]  req_htrans_o,
    output logic        req_hwrite_o,
    output logic [2:0]  req_hsize_o,
    output logic [5:0]  req_hparity_o
);

    mst_state_e state_q, state_d;
    ahb_req_t   hold_q,  hold_d;
    ahb_req_t   w_live_req;

    assign w_live_req = '{haddr:   haddr_i,
                          htrans:  htrans_i,
                          hwrite:  hwrite_i,
                          hsize:   hsize_i,
                          hparity: hparity_i};

    // Master-facing ready and request qualification; reset forces ready high
    always_comb begin
        hready_o = 1'b1;
        if (!rst_i) begin
            case (state_q)
                MST_IDLE:   hready_o = 1'b1;
                MST_HELD:   hready_o = 1'b0;
                MST_DPHASE: hready_o = slv_hready_i;
                default:    hready_o = 1'b1;
            endcase
        end
        live_o = hready_o && htrans_active(htrans_i);
        held_o = !rst_i && (state_q == MST_HELD);
    end

    // Forward the captured request while held, the live one otherwise
    always_comb begin
        req_haddr_o   = held_o ? hold_q.haddr   : w_live_req.haddr;
        req_htrans_o  = held_o ? hold_q.htrans  : w_live_req.htrans;
        req_hwrite_o  = held_o ? hold_q.hwrite  : w_live_req.hwrite;
        req_hsize_o   = held_o ? hold_q.hsize   : w_live_req.hsize;
        req_hparity_o = held_o ? hold_q.hparity : w_live_req.hparity;
    end

    // Next state: a sampled request either wins now or is parked
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (live_o) begin
            if (grant_i) begin
                state_d = MST_DPHASE;
            end else begin
                state_d = MST_HELD;
                hold_d  = w_live_req;
            end
        end else begin
            case (state_q)
                MST_HELD:   if (grant_i)      state_d = MST_DPHASE;
                MST_DPHASE: if (slv_hready_i) state_d = MST_IDLE;
                default:    state_d = state_q;
            endcase
        end
    end

    // State and hold register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_arbiter_2m.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_arbiter_2m
//  Description : Two-master (data / instruction) AHB-Lite arbiter onto one
//                slave port. Held requests outrank new ones, the data master
//                wins ties unless the instruction master has starved for
//                MAX_WAIT cycles. Data-phase signals follow a registered owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_arbiter_2m
    import p_hardisc::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    // Data master
    input  logic [31:0] s_d_haddr_i,
    input  logic [1:0]  s_d_htrans_i,
    input  logic        s_d_hwrite_i,
    input  logic [2:0]  s_d_hsize_i,
    input  logic [5:0]  s_d_hparity_i,
    input  logic [31:0] s_d_hwdata_i,
    input  logic [6:0]  s_d_hwchecksum_i,
    output logic        s_d_hready_o,
    output logic        s_d_hresp_o,
    output logic [31:0] s_d_hrdata_o,
    output logic [6:0]  s_d_hrchecksum_o,
    // Instruction master
    input  logic [31:0] s_i_haddr_i,
    input  logic [1:0]  s_i_htrans_i,
    input  logic        s_i_hwrite_i,
    input  logic [2:0]  s_i_hsize_i,
    input  logic [5:0]  s_i_hparity_i,
    input  logic [31:0] s_i_hwdata_i,
    input  logic [6:0]  s_i_hwchecksum_i,
    output logic        s_i_hready_o,
    output logic        s_i_hresp_o,
    output logic [31:0] s_i_hrdata_o,
    output logic [6:0]  s_i_hrchecksum_o,
    // Shared slave port
    output logic [31:0] s_s_haddr_o,
    output logic [1:0]  s_s_htrans_o,
    output logic        s_s_hwrite_o,
    output logic [2:0]  s_s_hsize_o,
    output logic [5:0]  s_s_hparity_o,
    output logic [31:0] s_s_hwdata_o,
    output logic [6:0]  s_s_hwchecksum_o,
    input  logic        s_s_hready_i,
    input  logic        s_s_hresp_i,
    input  logic [31:0] s_s_hrdata_i,
    input  logic [6:0]  s_s_hrchecksum_i
);

    localparam int              WAIT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);

    // Per-master status and forwardable requests
    logic        w_d_live, w_d_held, w_i_live, w_i_held;
    logic        w_grant_d, w_grant_i;
    logic [31:0] w_d_haddr,   w_i_haddr;
    logic [1:0]  w_d_htrans,  w_i_htrans;
    logic        w_d_hwrite,  w_i_hwrite;
    logic [2:0]  w_d_hsize,   w_i_hsize;
    logic [5:0]  w_d_hparity, w_i_hparity;

    // Arbiter state
    owner_e            owner_q, owner_d, w_owner;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    logic [31:0]       last_addr_q, last_addr_d;

    logic w_slot_free, w_i_first, w_i_cand;

    ahb_hold_stage u_hold_d (
        .clk_i         (s_clk_i),
        .rst_i         (s_reset_i),
        .haddr_i       (s_d_haddr_i),
        .htrans_i      (s_d_htrans_i),
        .hwrite_i      (s_d_hwrite_i),
        .hsize_i       (s_d_hsize_i),
        .hparity_i     (s_d_hparity_i),
        .slv_hready_i  (s_s_hready_i),
        .grant_i       (w_grant_d),
        .hready_o      (s_d_hready_o),
        .live_o        (w_d_live),
        .held_o        (w_d_held),
        .req_haddr_o   (w_d_haddr),
        .req_htrans_o  (w_d_htrans),
        .req_hwrite_o  (w_d_hwrite),
        .req_hsize_o   (w_d_hsize),
        .req_hparity_o (w_d_hparity)
    );

    ahb_hold_stage u_hold_i (
        .clk_i         (s_clk_i),
        .rst_i         (s_reset_i),
        .haddr_i       (s_i_haddr_i),
        .htrans_i      (s_i_htrans_i),
        .hwrite_i      (s_i_hwrite_i),
        .hsize_i       (s_i_hsize_i),
        .hparity_i     (s_i_hparity_i),
        .slv_hready_i  (s_s_hready_i),
        .grant_i       (w_grant_i),
        .hready_o      (s_i_hready_o),
        .live_o        (w_i_live),
        .held_o        (w_i_held),
        .req_haddr_o   (w_i_haddr),
        .req_htrans_o  (w_i_htrans),
        .req_hwrite_o  (w_i_hwrite),
        .req_hsize_o   (w_i_hsize),
        .req_hparity_o (w_i_hparity)
    );

    assign w_slot_free = s_s_hready_i && !s_reset_i;
    assign w_i_first   = (wait_q == c_MAX_WAIT);
    assign w_i_cand    = w_i_held || w_i_live;

    // Grant: held requests first, then live; D wins ties unless I has starved
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (w_slot_free) begin
            if (w_d_held || w_i_held) begin
                if (w_d_held && w_i_held) begin
                    w_grant_i = w_i_first;
                    w_grant_d = !w_i_first;
                end else begin
                    w_grant_d = w_d_held;
                    w_grant_i = w_i_held;
                end
            end else if (w_d_live && w_i_live) begin
                w_grant_i = w_i_first;
                w_grant_d = !w_i_first;
            end else begin
                w_grant_d = w_d_live;
                w_grant_i = w_i_live;
            end
        end
    end

    // Slave address phase: winner's request, else IDLE with the last address
    always_comb begin
        s_s_haddr_o   = s_reset_i ? 32'h0 : last_addr_q;
        s_s_htrans_o  = c_HTRANS_IDLE;
        s_s_hwrite_o  = 1'b0;
        s_s_hsize_o   = 3'b000;
        s_s_hparity_o = 6'b000000;
        if (w_grant_d) begin
            s_s_haddr_o   = w_d_haddr;
            s_s_htrans_o  = w_d_htrans;
            s_s_hwrite_o  = w_d_hwrite;
            s_s_hsize_o   = w_d_hsize;
            s_s_hparity_o = w_d_hparity;
        end else if (w_grant_i) begin
            s_s_haddr_o   = w_i_haddr;
            s_s_htrans_o  = w_i_htrans;
            s_s_hwrite_o  = w_i_hwrite;
            s_s_hsize_o   = w_i_hsize;
            s_s_hparity_o = w_i_hparity;
        end
    end

    // Data phase: write data and error response follow the registered owner
    always_comb begin
        w_owner          = s_reset_i ? OWN_NONE : owner_q;
        s_s_hwdata_o     = 32'h0;
        s_s_hwchecksum_o = 7'h0;
        case (w_owner)
            OWN_D: begin
                s_s_hwdata_o     = s_d_hwdata_i;
                s_s_hwchecksum_o = s_d_hwchecksum_i;
            end
            OWN_I: begin
                s_s_hwdata_o     = s_i_hwdata_i;
                s_s_hwchecksum_o = s_i_hwchecksum_i;
            end
            default: begin
                s_s_hwdata_o     = 32'h0;
                s_s_hwchecksum_o = 7'h0;
            end
        endcase
        s_d_hresp_o      = (w_owner == OWN_D) && s_s_hresp_i;
        s_i_hresp_o      = (w_owner == OWN_I) && s_s_hresp_i;
        s_d_hrdata_o     = s_s_hrdata_i;
        s_i_hrdata_o     = s_s_hrdata_i;
        s_d_hrchecksum_o = s_s_hrchecksum_i;
        s_i_hrchecksum_o = s_s_hrchecksum_i;
    end

    // Next owner, starvation counter and remembered address
    always_comb begin
        owner_d     = owner_q;
        wait_d      = wait_q;
        last_addr_d = last_addr_q;
        if (s_s_hready_i) begin
            if (w_grant_d)      owner_d = OWN_D;
            else if (w_grant_i) owner_d = OWN_I;
            else                owner_d = OWN_NONE;
        end
        if (!w_i_cand || w_grant_i) begin
            wait_d = '0;
        end else if (wait_q != c_MAX_WAIT) begin
            wait_d = wait_q + 1'b1;
        end
        if (w_grant_d || w_grant_i) begin
            last_addr_d = s_s_haddr_o;
        end
    end

    // Arbiter registers
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            owner_q     <= OWN_NONE;
            wait_q      <= '0;
            last_addr_q <= 32'h0;
        end else begin
            owner_q     <= owner_d;
            wait_q      <= wait_d;
            last_addr_q <= last_addr_d;
        end
    end

endmodule
`default_nettype wire
